// File: rtl/sram_pkg.sv
// Shared types for the pipelined single-port SRAM: read-during-write mode
// and controller state encodings.
package sram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/sram_be_array.sv
// Byte-enabled synchronous 1RW storage with registered read (old data on
// read-during-write). Optional per-byte parity plane when PAR_EN is set.
module sram_be_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter bit PAR_EN     = 1'b0
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wpar_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [DATA_WIDTH/8-1:0] rpar_o
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < NB; i++) begin
          if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

  generate
    if (PAR_EN) begin : g_par
      logic [NB-1:0] par_mem [DEPTH];
      logic [NB-1:0] rpar_q;

      always_ff @(posedge clk) begin
        if (en_i) begin
          if (we_i) begin
            for (int i = 0; i < NB; i++) begin
              if (be_i[i]) par_mem[addr_i][i] <= wpar_i[i];
            end
          end
          rpar_q <= par_mem[addr_i];
        end
      end

      assign rpar_o = rpar_q;
    end else begin : g_nopar
      logic unused_wpar;
      assign unused_wpar = ^wpar_i;
      assign rpar_o      = '0;
    end
  endgenerate

endmodule

// File: rtl/sram1rw_pipe.sv
// Pipelined single-port SRAM with post-reset zero fill and configurable
// read-during-write result. Define SRAM1RW_PIPE_PARITY_EN for byte parity.
module sram1rw_pipe
  import sram_pkg::*;
#(
  parameter int        ADDR_WIDTH = 8,
  parameter int        DATA_WIDTH = 32,
  parameter int        OUT_REG    = 0,
  parameter rdw_mode_e RDW_MODE   = RDW_READ_FIRST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    perr,
  output logic                    init_done
);
  localparam int NB = DATA_WIDTH / BYTE_W;
`ifdef SRAM1RW_PIPE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit WF = (RDW_MODE == RDW_WRITE_FIRST);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  logic                  in_init, accept;
  logic                  arr_en, arr_we;
  logic [NB-1:0]         arr_be, wpar, rpar_arr;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata, rdata_arr;

  // The zero-fill sweep owns the array port until the counter wraps.
  assign in_init   = (state_q == ST_INIT);
  assign accept    = req_valid && req_ready;
  assign arr_en    = in_init | accept;
  assign arr_we    = in_init | we;
  assign arr_be    = in_init ? {NB{1'b1}} : be;
  assign arr_addr  = in_init ? cnt_q : addr;
  assign arr_wdata = in_init ? '0 : wdata;

  sram_be_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PAR_EN     (PAR_EN)
  ) u_array (
    .clk     (clk),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .wpar_i  (wpar),
    .rdata_o (rdata_arr),
    .rpar_o  (rpar_arr)
  );

  logic                  v1_q, wr1_q;
  logic [NB-1:0]         be1_q, wp1_q;
  logic [DATA_WIDTH-1:0] wd1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      wr1_q <= 1'b0;
    end else begin
      v1_q  <= accept;
      wr1_q <= accept & we;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      be1_q <= be;
      wd1_q <= wdata;
      wp1_q <= wpar;
    end
  end

  logic [DATA_WIDTH-1:0] mdata;
  logic [NB-1:0]         mpar, par_bad, take_new;
  logic                  perr_calc;

  // Write-first returns the merged word: enabled lanes take the new byte
  // and its fresh parity, the rest come from the stored word.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wpar[gi]             = ^arr_wdata[gi*8 +: 8];
    assign take_new[gi]         = WF && wr1_q && be1_q[gi];
    assign mdata[gi*8 +: 8]     = take_new[gi] ? wd1_q[gi*8 +: 8] : rdata_arr[gi*8 +: 8];
    assign mpar[gi]             = take_new[gi] ? wp1_q[gi] : rpar_arr[gi];
    assign par_bad[gi]          = (^mdata[gi*8 +: 8]) ^ mpar[gi];
  end

  assign perr_calc = PAR_EN & (|par_bad);

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  rvalid_q, perr_q;
      logic [DATA_WIDTH-1:0] rdata_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rvalid_q <= 1'b0;
          perr_q   <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= v1_q;
          perr_q   <= v1_q & perr_calc;
          if (v1_q) rdata_q <= mdata;
        end
      end

      assign rvalid = rvalid_q;
      assign rdata  = rdata_q;
      assign perr   = perr_q;
    end else begin : g_noreg
      logic [DATA_WIDTH-1:0] hold_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)       hold_q <= '0;
        else if (v1_q) hold_q <= mdata;
      end

      assign rvalid = v1_q;
      assign rdata  = v1_q ? mdata : hold_q;
      assign perr   = v1_q & perr_calc;
    end
  endgenerate

endmodule
